// File: rtl/led_blink_sched_if.sv
// Command handshake bundle for led_blink_sched.
// Master drives the command, slave returns ready.
interface led_blink_sched_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ch;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_period;
    logic [7:0]  cmd_count;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_mode,
        output cmd_period,
        output cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_mode,
        input  cmd_period,
        input  cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/led_blink_sched.sv
// Four-channel LED scheduler: OFF/ON/BLINK/BURST per channel,
// driven from one shared tick prescaler. LEDs are active-low.
module led_blink_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000
) (
    input  logic                  Clk50M,
    input  logic                  Rst_n,
    led_blink_sched_if.slave      cmd,
    output logic [3:0]            led,
    output logic [3:0]            busy,
    output logic [3:0]            done
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TMAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BURST = 2'd3;

    typedef enum logic [1:0] {
        S_OFF,
        S_ON,
        S_BLINK,
        S_BURST
    } state_t;

    logic [PW-1:0] pre_q;
    logic          tick;
    logic          rdy_q;
    logic          acc;
    logic [15:0]   hp_new;

    state_t      st_q  [4];
    state_t      st_d  [4];
    logic [15:0] ph_q  [4];
    logic [15:0] ph_d  [4];
    logic [15:0] hp_q  [4];
    logic [15:0] hp_d  [4];
    logic [7:0]  rem_q [4];
    logic [7:0]  rem_d [4];
    logic [3:0]  led_q;
    logic [3:0]  led_d;
    logic [3:0]  done_q;
    logic [3:0]  done_d;

    assign acc           = cmd.cmd_valid & rdy_q;
    assign cmd.cmd_ready = rdy_q;
    assign tick          = (pre_q == TMAX);
    assign hp_new        = (cmd.cmd_period == 16'd0) ? 16'd1
                                                     : cmd.cmd_period;
    assign led           = led_q;
    assign done          = done_q;

    // Free-running time base; commands never disturb it.
    always_ff @(posedge Clk50M) begin
        if (!Rst_n) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Ready drops for one cycle after each acceptance.
    always_ff @(posedge Clk50M) begin
        if (!Rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= ~acc;
        end
    end

    // Per-channel state registers.
    always_ff @(posedge Clk50M) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= S_OFF;
                ph_q[i]  <= '0;
                hp_q[i]  <= 16'd1;
                rem_q[i] <= '0;
            end
            led_q  <= 4'b1111;
            done_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                ph_q[i]  <= ph_d[i];
                hp_q[i]  <= hp_d[i];
                rem_q[i] <= rem_d[i];
            end
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    // Next state: a command to a channel overrides its tick activity.
    always_comb begin
        led_d  = led_q;
        done_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = st_q[i];
            ph_d[i]  = ph_q[i];
            hp_d[i]  = hp_q[i];
            rem_d[i] = rem_q[i];
            if (acc && (cmd.cmd_ch == 2'(i))) begin
                hp_d[i]  = hp_new;
                ph_d[i]  = '0;
                rem_d[i] = '0;
                unique case (cmd.cmd_mode)
                    M_OFF: begin
                        st_d[i]  = S_OFF;
                        led_d[i] = 1'b1;
                    end
                    M_ON: begin
                        st_d[i]  = S_ON;
                        led_d[i] = 1'b0;
                    end
                    M_BLINK: begin
                        st_d[i]  = S_BLINK;
                        led_d[i] = 1'b0;
                    end
                    M_BURST: begin
                        if (cmd.cmd_count == 8'd0) begin
                            st_d[i]   = S_OFF;
                            led_d[i]  = 1'b1;
                            done_d[i] = 1'b1;
                        end else begin
                            st_d[i]  = S_BURST;
                            led_d[i] = 1'b0;
                            rem_d[i] = cmd.cmd_count;
                        end
                    end
                    default: ;
                endcase
            end else if (tick &&
                         (st_q[i] == S_BLINK ||
                          st_q[i] == S_BURST)) begin
                if (ph_q[i] == hp_q[i] - 16'd1) begin
                    ph_d[i]  = '0;
                    led_d[i] = ~led_q[i];
                    if (st_q[i] == S_BURST && !led_q[i] &&
                        rem_q[i] != 8'd0) begin
                        rem_d[i] = rem_q[i] - 8'd1;
                        if (rem_q[i] == 8'd1) begin
                            st_d[i]   = S_OFF;
                            led_d[i]  = 1'b1;
                            done_d[i] = 1'b1;
                        end
                    end
                end else begin
                    ph_d[i] = ph_q[i] + 16'd1;
                end
            end
        end
    end

    // Busy flags straight from channel state.
    always_comb begin
        busy = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            busy[i] = (st_q[i] == S_BLINK) || (st_q[i] == S_BURST);
        end
    end

endmodule
